mem_bus_arbiter: RTL

- Shares the single 128-bit memory bus between I-cache refill requests and D-cache refill/writeback requests.
- Arbitrates round-robin and issues one transaction at a time.
- Holds ownership until the memory completes, then returns the completion to the owning cache.
- Includes a watchdog that aborts hung transactions with an error pulse.
- Sits between both cache controllers and the memory interface.

---
 rtl/mem_bus_arbiter_pkg.sv | 12 +
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter_rr_arb2.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the I-cache/D-cache memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned PHY_LEN     = 20;
  localparam int unsigned MBLEN       = 128;
  localparam int unsigned ARB_TIMEOUT = 255;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;
  typedef logic [MBLEN-1:0] mem_line_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = PHY_LEN,
  parameter int unsigned LINE_W = MBLEN
);

  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_gnt_o;
  logic              ic_rvalid_o;

  logic              dc_req_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [LINE_W-1:0] dc_wdata_i;
  logic              dc_gnt_o;
  logic              dc_rvalid_o;

  logic [LINE_W-1:0] rdata_o;
  logic              err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic              mem_rvalid_i;
  logic [LINE_W-1:0] mem_rdata_i;

  modport slave (
    input  ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
           mem_ack_i, mem_rvalid_i, mem_rdata_i,
    output ic_gnt_o, ic_rvalid_o, dc_gnt_o, dc_rvalid_o, rdata_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
           mem_ack_i, mem_rvalid_i, mem_rdata_i,
    input  ic_gnt_o, ic_rvalid_o, dc_gnt_o, dc_rvalid_o, rdata_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker; bit 0 = I-cache, bit 1 = D-cache.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Set when the D-cache was served last; reset favours the D-cache on a tie.
  logic last_dc;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) gnt = last_dc ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       last_dc <= 1'b0;
    else if (|gnt) last_dc <= gnt[1];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between I-cache and D-cache, one transaction at a time,
// with a watchdog that aborts a hung transaction and flags it on err_o.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = PHY_LEN,
  parameter int unsigned LINE_W  = MBLEN,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  arb_state_t        state_q;
  owner_t            owner_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic              ic_rvalid_q;
  logic              dc_rvalid_q;
  logic              err_q;
  logic [31:0]       cnt_q;

  logic       idle;
  logic       busy;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       complete;
  logic       timeout_hit;
  logic       abort;

  assign idle = (state_q == IDLE);
  assign busy = (state_q == ISSUE) || (state_q == WAIT);
  assign req  = {bus.dc_req_i, bus.ic_req_i};

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .en  (idle),
    .req (req),
    .gnt (gnt)
  );

  // A completion seen in the same cycle as the watchdog expiry wins over the abort.
  assign complete    = ((state_q == ISSUE) && bus.mem_ack_i && bus.mem_rvalid_i) ||
                       ((state_q == WAIT) && bus.mem_rvalid_i);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);
  assign abort       = busy && !complete && timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IC;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            owner_q     <= gnt[1] ? OWN_DC : OWN_IC;
            mem_we_q    <= gnt[1] & bus.dc_we_i;
            mem_addr_q  <= gnt[1] ? bus.dc_addr_i : bus.ic_addr_i;
            mem_wdata_q <= gnt[1] ? bus.dc_wdata_i : '0;
            mem_req_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          cnt_q <= cnt_q + 32'd1;
          if (complete || abort) begin
            ic_rvalid_q <= (owner_q == OWN_IC);
            dc_rvalid_q <= (owner_q == OWN_DC);
            err_q       <= abort;
            mem_req_q   <= 1'b0;
            if (complete && !mem_we_q) rdata_q <= bus.mem_rdata_i;
            state_q     <= RESP;
          end else if ((state_q == ISSUE) && bus.mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ic_gnt_o    = gnt[0];
  assign bus.dc_gnt_o    = gnt[1];
  assign bus.ic_rvalid_o = ic_rvalid_q;
  assign bus.dc_rvalid_o = dc_rvalid_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule
